// File: rtl/wb_arb_pkg.sv
// Shared types and constants for the WISHBONE round-robin arbiter.
// Holds the FSM state enum, counter width and a pointer-width helper.
package wb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    OWNED   = 2'd1,
    BACKOFF = 2'd2
  } state_t;

  localparam int WB_ARB_CNT_W = 16;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/wb_rr_pick.sv
// Combinational round-robin picker: searches req from last+1, wrapping.
// Ports: req, last, excl/excl_en (index to skip) -> found, idx.
module wb_rr_pick #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] last,
  input  logic [W-1:0] excl,
  input  logic         excl_en,
  output logic         found,
  output logic [W-1:0] idx
);

  int k;

  // i runs 1..N so that last itself is the final candidate.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    k     = 0;
    for (int i = 1; i <= N; i++) begin
      k = (int'(last) + i) % N;
      if (!found && req[k] &&
          !(excl_en && (k == int'(excl)))) begin
        found = 1'b1;
        idx   = W'(k);
      end
    end
  end

endmodule

// File: rtl/wb_rr_arbiter.sv
// Round-robin WISHBONE shared-bus arbiter, ownership held until CYC drops.
// Ports: CLK_I, RST_I (sync, low), CYC_I, ACK_I -> GNT_O, GNT_VLD_O,
// CYC_O, TOUT_O. Define WB_ARB_TIMEOUT_EN for the ACK watchdog.
module wb_rr_arbiter
  import wb_arb_pkg::*;
#(
  parameter int NUM_MASTERS    = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                   CLK_I,
  input  logic                   RST_I,
  input  logic [NUM_MASTERS-1:0] CYC_I,
  input  logic                   ACK_I,
  output logic [NUM_MASTERS-1:0] GNT_O,
  output logic                   GNT_VLD_O,
  output logic                   CYC_O,
  output logic                   TOUT_O
);

  localparam int W = clog2(NUM_MASTERS);

  state_t                 state, state_n;
  logic [NUM_MASTERS-1:0] gnt_n;
  logic [W-1:0]           last, last_n;
  logic [NUM_MASTERS-1:0] lockout;
  logic [NUM_MASTERS-1:0] elig;
  logic                   found;
  logic [W-1:0]           pick;
  logic                   tout_n;
  logic                   owned;

  assign owned     = (state == OWNED);
  assign elig      = CYC_I & ~lockout;
  assign GNT_VLD_O = |GNT_O;
  assign CYC_O     = |(CYC_I & GNT_O);

  // last doubles as the owner index while OWNED.
  wb_rr_pick #(
    .N(NUM_MASTERS),
    .W(W)
  ) u_pick (
    .req    (elig),
    .last   (last),
    .excl   (last),
    .excl_en(owned),
    .found  (found),
    .idx    (pick)
  );

`ifdef WB_ARB_TIMEOUT_EN
  localparam logic [WB_ARB_CNT_W-1:0] TO_M1 =
    WB_ARB_CNT_W'(TIMEOUT_CYCLES - 1);

  logic [WB_ARB_CNT_W-1:0] cnt, cnt_n;
  logic [NUM_MASTERS-1:0]  lock_set;
  logic [NUM_MASTERS-1:0]  lock_n;
`else
  logic unused_ok;
  assign unused_ok = ^{ACK_I, WB_ARB_CNT_W'(TIMEOUT_CYCLES)};
  assign lockout   = '0;
`endif

  always_comb begin
    state_n = state;
    gnt_n   = GNT_O;
    last_n  = last;
    tout_n  = 1'b0;
`ifdef WB_ARB_TIMEOUT_EN
    cnt_n    = cnt;
    lock_set = '0;
`endif
    unique case (state)
      IDLE: begin
        if (found) begin
          state_n = OWNED;
          gnt_n   = NUM_MASTERS'(1) << pick;
          last_n  = pick;
        end
      end
      OWNED: begin
        if (!CYC_I[last]) begin
          if (found) begin
            gnt_n  = NUM_MASTERS'(1) << pick;
            last_n = pick;
          end else begin
            state_n = IDLE;
            gnt_n   = '0;
          end
        end
`ifdef WB_ARB_TIMEOUT_EN
        // ACK on the terminal edge clears the count and wins.
        else if (ACK_I) begin
          cnt_n = '0;
        end else if (cnt == TO_M1) begin
          state_n  = BACKOFF;
          gnt_n    = '0;
          tout_n   = 1'b1;
          cnt_n    = '0;
          lock_set = NUM_MASTERS'(1) << last;
        end else begin
          cnt_n = cnt + 1'b1;
        end
`endif
      end
      BACKOFF: begin
        state_n = IDLE;
        gnt_n   = '0;
      end
      default: begin
        state_n = IDLE;
        gnt_n   = '0;
      end
    endcase
`ifdef WB_ARB_TIMEOUT_EN
    if (gnt_n != GNT_O) cnt_n = '0;
    // A lock lifts once its master has let go of CYC for a cycle.
    lock_n = (lockout & CYC_I) | lock_set;
`endif
  end

  always_ff @(posedge CLK_I) begin
    if (!RST_I) begin
      state  <= IDLE;
      GNT_O  <= '0;
      last   <= W'(NUM_MASTERS - 1);
      TOUT_O <= 1'b0;
    end else begin
      state  <= state_n;
      GNT_O  <= gnt_n;
      last   <= last_n;
      TOUT_O <= tout_n;
    end
  end

`ifdef WB_ARB_TIMEOUT_EN
  always_ff @(posedge CLK_I) begin
    if (!RST_I) begin
      cnt     <= '0;
      lockout <= '0;
    end else begin
      cnt     <= cnt_n;
      lockout <= lock_n;
    end
  end
`endif

  a_own_onehot: assert property (
    @(posedge CLK_I) disable iff (!RST_I)
    owned |-> (GNT_O == (NUM_MASTERS'(1) << last))
  );

  a_gnt_onehot0: assert property (
    @(posedge CLK_I) disable iff (!RST_I)
    $onehot0(GNT_O)
  );

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Directed bench for wb_rr_arbiter (4 masters, TIMEOUT_CYCLES=8).
// Timeout section applies when WB_ARB_TIMEOUT_EN is defined.
module tb_wb_rr_arbiter;

  logic       clk;
  logic       rst_n;
  logic [3:0] cyc;
  logic       ack;
  logic [3:0] gnt;
  logic       gnt_vld;
  logic       cyc_o;
  logic       tout;

  int n_chk;
  int n_pass;

  wb_rr_arbiter #(
    .NUM_MASTERS   (4),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .CLK_I    (clk),
    .RST_I    (rst_n),
    .CYC_I    (cyc),
    .ACK_I    (ack),
    .GNT_O    (gnt),
    .GNT_VLD_O(gnt_vld),
    .CYC_O    (cyc_o),
    .TOUT_O   (tout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [3:0] exp_g;

  initial begin
    n_chk  = 0;
    n_pass = 0;
    rst_n  = 1'b0;
    cyc    = 4'b1111;
    ack    = 1'b0;

    // reset hold
    step();
    step();
    chk("rst_gnt", gnt, 4'b0000);
    chk("rst_vld", gnt_vld, 1'b0);
    chk("rst_cyco", cyc_o, 1'b0);
    chk("rst_tout", tout, 1'b0);
    rst_n = 1'b1;
    step();
    chk("rel_gnt", gnt, 4'b0001);
    chk("rel_vld", gnt_vld, 1'b1);
    chk("rel_cyco", cyc_o, 1'b1);
    cyc = 4'b0000;
    step();
    chk("rel_idle", gnt, 4'b0000);

    // single request
    cyc = 4'b0100;
    step();
    chk("single_gnt", gnt, 4'b0100);
    cyc = 4'b0000;
    step();
    chk("single_drop", gnt, 4'b0000);
    chk("single_cyco", cyc_o, 1'b0);

    // handover without bubble (last = 2)
    cyc = 4'b0010;
    step();
    chk("ho_m1", gnt, 4'b0010);
    cyc = 4'b1011;
    step();
    chk("ho_hold", gnt, 4'b0010);
    cyc = 4'b1001;
    step();
    chk("ho_pass", gnt, 4'b1000);
    chk("ho_cyco", cyc_o, 1'b1);
    cyc = 4'b0000;
    step();
    chk("ho_idle", gnt, 4'b0000);

    // fairness (last = 3): 0,1,2,3,0
    cyc = 4'b1111;
    step();
    for (int k = 0; k < 5; k++) begin
      exp_g = 4'b0001 << (k % 4);
      chk("fair_gnt", gnt, exp_g);
      step();
      chk("fair_hold1", gnt, exp_g);
      step();
      chk("fair_hold2", gnt, exp_g);
      cyc = 4'b1111 ^ exp_g;
      step();
      cyc = 4'b1111;
    end
    chk("fair_next", gnt, 4'b0010);
    cyc = 4'b0000;
    step();
    chk("fair_idle", gnt, 4'b0000);

    // reset mid-operation (last = 1)
    cyc = 4'b0100;
    step();
    chk("mid_own", gnt, 4'b0100);
    for (int i = 0; i < 3; i++) begin
      ack = ~ack;
      step();
    end
    chk("mid_hold", gnt, 4'b0100);
    rst_n = 1'b0;
    step();
    chk("mid_rst", gnt, 4'b0000);
    chk("mid_rst_vld", gnt_vld, 1'b0);
    ack   = 1'b0;
    cyc   = 4'b1001;
    rst_n = 1'b1;
    step();
    chk("mid_ptr", gnt, 4'b0001);
    cyc = 4'b0000;
    step();
    chk("mid_idle", gnt, 4'b0000);

`ifdef WB_ARB_TIMEOUT_EN
    // watchdog (last = 0)
    cyc = 4'b0001;
    step();
    chk("to_own", gnt, 4'b0001);
    cyc = 4'b0011;
    for (int i = 0; i < 7; i++) step();
    chk("to_pre", gnt, 4'b0001);
    chk("to_pre_tout", tout, 1'b0);
    step();
    chk("to_gnt", gnt, 4'b0000);
    chk("to_pulse", tout, 1'b1);
    step();
    chk("to_pulse_end", tout, 1'b0);
    chk("to_bo_gnt", gnt, 4'b0000);
    step();
    chk("to_m1", gnt, 4'b0010);
    cyc = 4'b0001;
    step();
    chk("to_lock1", gnt, 4'b0000);
    step();
    chk("to_lock2", gnt, 4'b0000);
    cyc = 4'b0000;
    step();
    cyc = 4'b0001;
    step();
    chk("to_unlock", gnt, 4'b0001);
    for (int i = 0; i < 7; i++) step();
    ack = 1'b1;
    step();
    chk("to_ack_gnt", gnt, 4'b0001);
    chk("to_ack_tout", tout, 1'b0);
    ack = 1'b0;
    cyc = 4'b0000;
    step();
    chk("to_end", gnt, 4'b0000);
`else
    // no watchdog: ownership is indefinite
    cyc = 4'b0001;
    step();
    chk("nto_own", gnt, 4'b0001);
    for (int i = 0; i < 20; i++) begin
      step();
      chk("nto_tout", tout, 1'b0);
    end
    chk("nto_hold", gnt, 4'b0001);
    cyc = 4'b0000;
    step();
    chk("nto_end", gnt, 4'b0000);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/wb_rr_arbiter.md
Name: wb_rr_arbiter

Overview:
- Round-robin arbiter that shares one WISHBONE shared-bus interconnect between up to NUM_MASTERS masters.
- Sits between the system controller's clock/reset outputs and the bus multiplexers.
- Issues a one-hot grant that selects the address/data/control mux.
- Holds ownership for the full duration of the owner's bus cycle, i.e. until that master negates CYC.

Parameters:
- NUM_MASTERS, 4, number of requesting masters (2..8).
- TIMEOUT_CYCLES, 255, cycles without ACK_I before forced release. Used only with WB_ARB_TIMEOUT_EN; range 1..65535.

Ports:
- CLK_I  input  1  bus clock.
- RST_I  input  1  reset, synchronous, active-low (0 = reset).
- CYC_I  input  NUM_MASTERS  per-master bus-cycle request.
- ACK_I  input  1  slave acknowledge, observed for the watchdog.
- GNT_O  output  NUM_MASTERS  one-hot grant; all-zero when the bus is idle.
- GNT_VLD_O  output  1  OR of GNT_O.
- CYC_O  output  1  CYC of the granted master, gated by grant, to the slave side.
- TOUT_O  output  1  one-cycle pulse on forced release. Constant 0 without the macro.

Behaviour:
- Reset (RST_I=0 at a CLK_I edge):
  - state=IDLE, GNT_O=0, GNT_VLD_O=0, TOUT_O=0.
  - Last-owner pointer = NUM_MASTERS-1, so master 0 has first priority.
  - Watchdog counter=0; lockout mask=0.
  - Reset overrides everything, including mid-transfer; grant drops on the next edge.
- CYC_O = |(CYC_I & GNT_O). It is combinational from registered GNT_O.
- State IDLE:
  - If any (CYC_I & ~lockout) is set, pick the requester via a round-robin search starting at last+1, wrapping modulo NUM_MASTERS.
  - On the next edge, GNT_O = one-hot(pick), last = pick, state=OWNED.
  - Grant latency: 1 cycle from CYC_I assertion.
- State OWNED:
  - While CYC_I[owner]=1, GNT_O is held. Other requests are ignored; there is no preemption.
  - When CYC_I[owner]=0, pick among other eligible requesters; the owner is excluded for that cycle. On the next edge:
    - if a requester is found: grant passes directly to the pick, with no idle bubble;
    - otherwise: GNT_O=0 and state=IDLE.
- Simultaneous requests: ties are resolved purely by round-robin order from last+1.
- Fairness: a master that keeps requesting is granted within NUM_MASTERS-1 ownership periods.
- A requester dropping CYC_I before it is granted is simply not picked. No request memory is kept.
- GNT_O is always one-hot or zero. Equivalence of GNT_O with the owner index is an assertion target.

Optional Feature:
- WB_ARB_TIMEOUT_EN defined:
  - A 16-bit counter clears on grant change and on ACK_I=1, and increments each OWNED cycle with ACK_I=0.
  - When the counter reaches TIMEOUT_CYCLES: state=BACKOFF for one cycle, GNT_O=0, TOUT_O=1.
  - lockout[owner] is set and the counter is cleared.
  - lockout[k] clears on any cycle with CYC_I[k]=0; a locked master is ineligible until then.
  - BACKOFF always goes to IDLE next.
  - ACK_I on the same edge as the terminal count wins, i.e. no timeout.
- Macro undefined:
  - No counter, no BACKOFF state, lockout tied to 0, TOUT_O tied to 0.
  - Ownership can be held indefinitely.

Decomposition:
- Package wb_arb_pkg holds:
  - the state enum (IDLE, OWNED, BACKOFF);
  - the constant WB_ARB_CNT_W=16;
  - the function clog2 used for the pointer width.
- One sub-module, wb_rr_pick: combinational round-robin picker.
  - Inputs: request vector, last pointer, exclude index.
  - Outputs: found flag and index.
  - The arbiter instantiates it once.

Test Plan:
- Reset: hold RST_I=0 with CYC_I=4'b1111 -> GNT_O=0, CYC_O=0. Release RST_I -> GNT_O=4'b0001 one cycle later.
- Single request: CYC_I=4'b0100 from IDLE -> GNT_O=4'b0100 after 1 edge. Drop CYC_I -> GNT_O=0 and IDLE after 1 edge.
- Handover without bubble: master 1 owns, CYC_I=4'b1011, master 1 drops -> GNT_O=4'b1000 on the next edge, never 0 in between.
- Fairness: all four hold CYC_I and each drops for one cycle after 3 owned cycles -> grant sequence 0,1,2,3,0. Max wait 3 ownerships.
- Reset mid-operation: RST_I=0 while master 2 owns with ACK_I toggling -> GNT_O=0 next edge. Pointer restarts so master 0 wins the next arbitration.
- Timeout (WB_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8): master 0 owns, ACK_I stuck 0 -> after 8 cycles GNT_O=0 and TOUT_O high for exactly 1 cycle. With CYC_I=4'b0011 master 1 is granted; master 0 is not granted until it has dropped CYC_I once.
